// File: rtl/prod_fold_j4.sv
// Receives 4-lane product groups from the unfolded multiplier, buffers up to DEPTH groups and
// replays them as a single-rate word stream in lane order 0..J-1.
module prod_fold_j4 #(
  parameter int unsigned W     = 10,
  parameter int unsigned J     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_0,
  input  logic [W-1:0] s_1,
  input  logic [W-1:0] s_2,
  input  logic [W-1:0] s_3,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_lane,
  output logic         out_last
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned GrpW  = J * W;

  logic [GrpW-1:0] mem_q [DEPTH];
  logic [GrpW-1:0] mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      lane_q, lane_d;

  logic [W-1:0]    words [J];
  logic            push;
  logic            pop_word;
  logic            release_grp;

  always_comb begin
    for (int i = 0; i < J; i++) begin
      words[i] = mem_q[rd_ptr_q][i*W +: W];
    end

    in_ready    = (count_q < CntW'(DEPTH));
    out_valid   = (count_q != '0);
    out_data    = out_valid ? words[lane_q] : '0;
    out_lane    = lane_q;
    out_last    = out_valid && (lane_q == 2'(J - 1));

    push        = in_valid && in_ready;
    pop_word    = out_valid && out_ready;
    release_grp = pop_word && (lane_q == 2'(J - 1));

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;

    if (push) begin
      mem_d[wr_ptr_q] = {s_3, s_2, s_1, s_0};
      wr_ptr_d        = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop_word) begin
      if (release_grp) begin
        lane_d   = '0;
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end

    // Simultaneous push and release leave the group count unchanged.
    unique case ({push, release_grp})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_prod_fold_j4.sv
// Randomised and directed bench for prod_fold_j4 against a word-queue reference model.
module tb_prod_fold_j4;

  localparam int unsigned W     = 10;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s_0, s_1, s_2, s_3;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_lane;
  logic         out_last;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference: flat queue of words still owed to the consumer, in emission order.
  logic [W-1:0] q [$];
  bit           model_known = 1'b0;

  prod_fold_j4 #(.W(W), .J(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_0       (s_0),
    .s_1       (s_1),
    .s_2       (s_2),
    .s_3       (s_3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned groups_held();
    return (q.size() + 3) / 4;
  endfunction

  function automatic int unsigned exp_lane();
    return (4 - (q.size() % 4)) % 4;
  endfunction

  // One clock: compare outputs, drive inputs, advance model, cross the edge.
  task automatic step(input bit rst, input bit iv, input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] a2, input logic [W-1:0] a3, input bit ordy);
    bit exp_valid;
    bit exp_ready;
    @(negedge clk);
    exp_valid = (q.size() != 0);
    exp_ready = (groups_held() < DEPTH);
    if (model_known) begin
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("out_data", 32'(out_data), exp_valid ? 32'(q[0]) : 32'd0);
      check_eq("out_lane", 32'(out_lane), exp_lane());
      check_eq("out_last", 32'(out_last), 32'(exp_valid && exp_lane() == 3));
    end
    reset     = rst;
    in_valid  = iv;
    s_0       = a0;
    s_1       = a1;
    s_2       = a2;
    s_3       = a3;
    out_ready = ordy;
    if (rst) begin
      q.delete();
      model_known = 1'b1;
    end else begin
      if (exp_valid && ordy) void'(q.pop_front());
      if (iv && exp_ready) begin
        q.push_back(a0);
        q.push_back(a1);
        q.push_back(a2);
        q.push_back(a3);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, '0, '0, '0, '0, ordy);
  endtask

  logic [W-1:0] g [4];
  bit           pend;
  bit           acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s_0 = '0; s_1 = '0; s_2 = '0; s_3 = '0;

    // Reset held two cycles with a group offered: nothing may be captured.
    step(1'b1, 1'b1, 10'd15, 10'd30, 10'd45, 10'd60, 1'b1);
    step(1'b1, 1'b1, 10'd15, 10'd30, 10'd45, 10'd60, 1'b1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Single group, consumer always ready.
    step(1'b0, 1'b1, 10'd15, 10'd30, 10'd45, 10'd60, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("single_data", 32'(out_data), 32'(15 * (i + 1)));
      check_eq("single_last", 32'(out_last), 32'(i == 3));
      idle(1'b1);
    end
    check_eq("single_drained", 32'(out_valid), 32'd0);

    // Backpressure on lane 1.
    step(1'b0, 1'b1, 10'd15, 10'd30, 10'd45, 10'd60, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold_data", 32'(out_data), 32'd30);
      check_eq("bp_hold_lane", 32'(out_lane), 32'd1);
      idle(1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Fill and stall.
    step(1'b0, 1'b1, 10'd1, 10'd2, 10'd3, 10'd4, 1'b0);
    step(1'b0, 1'b1, 10'd5, 10'd6, 10'd7, 10'd8, 1'b0);
    check_eq("fill_full", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b0);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
    check_eq("fill_lane3_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
    check_eq("fill_room", 32'(in_ready), 32'd1);
    check_eq("fill_next", 32'(out_data), 32'd5);
    step(1'b0, 1'b1, 10'd9, 10'd10, 10'd11, 10'd12, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_eq("fill_drained", 32'(out_valid), 32'd0);

    // Continuous streaming.
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, 10'(4 * i), 10'(4 * i + 1), 10'(4 * i + 2), 10'(4 * i + 3), 1'b1);
    end
    for (int i = 0; i < 10; i++) idle(1'b1);

    // Reset mid-group.
    step(1'b0, 1'b1, 10'd15, 10'd30, 10'd45, 10'd60, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b1);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_lane", 32'(out_lane), 32'd0);
    step(1'b0, 1'b1, 10'd3, 10'd6, 10'd9, 10'd12, 1'b1);
    check_eq("midrst_first", 32'(out_data), 32'd3);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Random traffic; producer holds an offered group until accepted.
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        for (int k = 0; k < 4; k++) g[k] = 10'($urandom);
        pend = 1'b1;
      end
      acc = pend && (groups_held() < DEPTH);
      step(($urandom_range(0, 199) == 0), pend, g[0], g[1], g[2], g[3],
           ($urandom_range(0, 3) != 0));
      if (acc || reset) pend = 1'b0;
    end
    for (int i = 0; i < 12; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prod_fold_j4.md
Name: prod_fold_j4

Overview:
- Output-side companion to the J=4 unfolded 5-bit multiplier.
- The multiplier emits four 10-bit product lanes (s_0..s_3) per clock. This block is the receiving end of that interface.
- It captures each 4-lane group with a valid/ready handshake, buffers up to DEPTH groups, and refolds them into a single serial product stream at one word per handshake, in lane order 0,1,2,3.
- It sits between the unfolded multiplier and any single-rate downstream consumer.

Parameters:
- W, 10, product word width (2 x 5-bit operands).
- J, 4, unfolding factor = lanes per group; the port list is fixed at 4 lanes.
- DEPTH, 2, group buffer depth in groups; must be a power of two and >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  4-lane group on s_0..s_3 is valid this cycle.
- in_ready  output  1  block can accept a group this cycle.
- s_0  input  W  lane 0 product (earliest sample of the group).
- s_1  input  W  lane 1 product.
- s_2  input  W  lane 2 product.
- s_3  input  W  lane 3 product (latest sample).
- out_data  output  W  serialized product word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_lane  output  2  lane index of the current out_data.
- out_last  output  1  high with lane 3 of each group.

Behaviour:
- Reset:
  - Applied on a rising edge while reset=1.
  - Clears group count, wr_ptr, rd_ptr and lane counter to 0.
  - Buffer contents are don't-care.
  - Outputs the cycle after reset: out_valid=0, out_data=0, out_lane=0, out_last=0, in_ready=1.
  - Reset mid-stream discards all buffered groups and any partially read group. No word is emitted after reset until a new group is accepted.
- in_ready:
  - in_ready = (count < DEPTH), decoded from registered count only.
  - A pop in the same cycle does NOT make room: when full, in_ready=0 even if the last word is being popped.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - Writes {s_3,s_2,s_1,s_0} into buffer[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - in_valid while in_ready=0 is ignored; the producer must hold the group.
- Output, combinational from registers:
  - out_valid = (count > 0).
  - out_data = buffer[rd_ptr][lane] when out_valid, else 0.
  - out_lane = lane.
  - out_last = out_valid && (lane == J-1).
- Pop:
  - On out_valid && out_ready, lane increments.
  - If lane == J-1: lane returns to 0, rd_ptr increments modulo DEPTH, and the group is released.
  - With out_ready=0, out_data and out_lane hold stable.
- Count update:
  - +1 on push only.
  - -1 on group release only.
  - Unchanged if both happen in the same cycle (possible only when count < DEPTH).
- Latency: a group pushed at edge k into an empty block gives out_valid=1 with lane 0 in cycle k+1 (1-cycle latency).
- Throughput:
  - Full rate is one word per cycle, i.e. one group per J cycles.
  - The producer is throttled by in_ready.
  - No data is lost or reordered under any out_ready pattern.
- Arithmetic: pass-through only, no sign or width change. Words are unsigned W-bit.
- Simultaneous events:
  - Push into an empty buffer while out_valid=0: no pop is possible that cycle.
  - Push and group release in the same cycle at count=1: count stays 1, and the next group is presented with lane 0 the next cycle with no bubble.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1; no word is ever emitted from that group.
- Single group: a=5, b=3, s_0..s_3 = 15,30,45,60, out_ready=1:
  - out_data sequence 15,30,45,60 in cycles k+1..k+4.
  - out_lane 0..3; out_last only on 60.
- Backpressure:
  - Same group, with out_ready low during the lane-1 cycle for 3 cycles.
  - out_data holds 30 with out_lane=1 for those 3 cycles, then 45, 60; no duplicates.
- Fill and stall: DEPTH=2, out_ready=0, present groups G0={1,2,3,4}, G1={5,6,7,8}, G2={9,10,11,12}:
  - in_ready drops after G1 is accepted, and G2 is held.
  - When out_ready=1, in_ready rises in the cycle after G0 lane 3 is popped.
  - Full order is 1..12.
- Continuous streaming: back-to-back groups with in_valid=1 and out_ready=1 -> an unbroken one-word-per-cycle stream, wr_ptr/rd_ptr wrap correctly, and out_last every 4th word.
- Reset mid-group: reset asserted after lane 1 of {15,30,45,60} -> the next cycle has out_valid=0 and lane=0; a new group {3,6,9,12} then streams from lane 0.
